btn_debounce_poly_eval: RTL and testbench

Front-end helper for the Simpson's-rule integrator FSM.
- Debounces the push button into a single-cycle `enable` pulse. The FSM uses that pulse to latch one switch word per press.
- Evaluates the cubic polynomial a_0 + a_1·x + a_2·x² + a_3·x³ at three abscissae in parallel, using combinational unsigned modulo-2^WIDTH arithmetic.
- The debounce path and the evaluator path are independent.

---
 rtl/btn_debounce_poly_eval.sv | 93 +++++++++
 tb/tb_btn_debounce_poly_eval.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_poly_eval.sv
// Push-button debouncer producing a one-cycle press pulse, plus three parallel
// combinational cubic polynomial evaluators (unsigned, modulo 2^WIDTH).
module btn_debounce_poly_eval #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic [WIDTH-1:0] a_0,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] a_3,
    input  logic [WIDTH-1:0] x_1,
    input  logic [WIDTH-1:0] x_2,
    input  logic [WIDTH-1:0] x_3,
    output logic             enable,
    output logic [WIDTH-1:0] value_1,
    output logic [WIDTH-1:0] value_2,
    output logic [WIDTH-1:0] value_3
);

    // Counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync_0_q, sync_0_d;
    logic            sync_1_q, sync_1_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            enable_q, enable_d;

    // Next state: two-flop synchronizer, stability counter, rising-edge pulse.
    always_comb begin
        sync_0_d = btn;
        sync_1_d = sync_0_q;
        cnt_d    = '0;
        level_d  = level_q;
        enable_d = 1'b0;
        if (sync_1_q != level_q) begin
            if (cnt_q == CntMax) begin
                // Stable for long enough: accept the new level.
                level_d  = sync_1_q;
                enable_d = sync_1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0_q <= 1'b0;
            sync_1_q <= 1'b0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            sync_0_q <= sync_0_d;
            sync_1_q <= sync_1_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            enable_q <= enable_d;
        end
    end

    assign enable = enable_q;

    // Horner form; truncating each intermediate to WIDTH is exact mod 2^WIDTH.
    function automatic logic [WIDTH-1:0] horner(
        input logic [WIDTH-1:0] c0,
        input logic [WIDTH-1:0] c1,
        input logic [WIDTH-1:0] c2,
        input logic [WIDTH-1:0] c3,
        input logic [WIDTH-1:0] x
    );
        logic [WIDTH-1:0] acc;
        acc = c3;
        acc = acc * x + c2;
        acc = acc * x + c1;
        acc = acc * x + c0;
        return acc;
    endfunction

    // Three independent evaluators sharing the coefficients.
    always_comb begin
        value_1 = horner(a_0, a_1, a_2, a_3, x_1);
        value_2 = horner(a_0, a_1, a_2, a_3, x_2);
        value_3 = horner(a_0, a_1, a_2, a_3, x_3);
    end

endmodule

// File: tb/tb_btn_debounce_poly_eval.sv
// Self-checking bench: debounce behaviour against a sample-window model,
// polynomial outputs against a direct-form wide-arithmetic model.
module tb_btn_debounce_poly_eval;

    localparam int unsigned W  = 16;
    localparam int unsigned DC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn;
    logic [W-1:0] a_0, a_1, a_2, a_3, x_1, x_2, x_3;
    logic         enable;
    logic [W-1:0] value_1, value_2, value_3;

    int n_checks = 0;
    int n_errors = 0;

    btn_debounce_poly_eval #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .a_0    (a_0),
        .a_1    (a_1),
        .a_2    (a_2),
        .a_3    (a_3),
        .x_1    (x_1),
        .x_2    (x_2),
        .x_3    (x_3),
        .enable (enable),
        .value_1(value_1),
        .value_2(value_2),
        .value_3(value_3)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Debounce model: raw samples delayed two edges give the synchronized view;
    // the level flips once the last DC synchronized samples all disagree with it.
    bit hist[$];
    bit wq[$];
    bit lvl;
    bit exp_en;
    int edge_cnt;
    int pulses;
    int first_pulse;

    task automatic clear_stats();
        edge_cnt    = 0;
        pulses      = 0;
        first_pulse = -1;
    endtask

    task automatic step();
        bit bs;
        bit all_diff;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            wq.delete();
            lvl    = 1'b0;
            exp_en = 1'b0;
        end else begin
            bs = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
            hist.push_back(btn);
            if (hist.size() > 2) void'(hist.pop_front());
            wq.push_back(bs);
            if (wq.size() > DC) void'(wq.pop_front());
            exp_en   = 1'b0;
            all_diff = (wq.size() == DC);
            foreach (wq[i]) if (wq[i] == lvl) all_diff = 1'b0;
            if (all_diff) begin
                lvl    = ~lvl;
                exp_en = lvl;
                wq.delete();
            end
        end
        edge_cnt++;
        #1;
        check_eq("enable", enable, exp_en);
        if (enable === 1'b1) begin
            pulses++;
            if (first_pulse < 0) first_pulse = edge_cnt;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [W-1:0] ref_poly(
        input logic [W-1:0] c0, input logic [W-1:0] c1,
        input logic [W-1:0] c2, input logic [W-1:0] c3,
        input logic [W-1:0] x
    );
        longint unsigned xx, s;
        xx = 64'(x);
        s  = 64'(c0) + 64'(c1) * xx + 64'(c2) * xx * xx + 64'(c3) * xx * xx * xx;
        return s[W-1:0];
    endfunction

    task automatic check_poly(input string tag);
        #1;
        check_eq({tag, "_v1"}, 32'(value_1), 32'(ref_poly(a_0, a_1, a_2, a_3, x_1)));
        check_eq({tag, "_v2"}, 32'(value_2), 32'(ref_poly(a_0, a_1, a_2, a_3, x_2)));
        check_eq({tag, "_v3"}, 32'(value_3), 32'(ref_poly(a_0, a_1, a_2, a_3, x_3)));
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        {a_0, a_1, a_2, a_3, x_1, x_2, x_3} = '0;
        clear_stats();

        // Evaluator, directed values.
        a_0 = 16'd1; a_1 = 16'd2; a_2 = 16'd3; a_3 = 16'd4;
        x_1 = 16'd2; x_2 = 16'd0; x_3 = 16'd1;
        #1;
        check_eq("poly_basic_v1", 32'(value_1), 32'd49);
        check_eq("poly_basic_v2", 32'(value_2), 32'd1);
        check_eq("poly_basic_v3", 32'(value_3), 32'd10);
        a_0 = 16'd0; a_1 = 16'd0; a_2 = 16'd0; a_3 = 16'd1; x_1 = 16'd41;
        #1;
        check_eq("poly_ovf_cube", 32'(value_1), 32'd3385);
        a_0 = 16'd65535; a_1 = 16'd1; a_2 = 16'd0; a_3 = 16'd0; x_2 = 16'd1;
        #1;
        check_eq("poly_ovf_wrap", 32'(value_2), 32'd0);

        // Evaluator, random values, including during reset.
        for (int i = 0; i < 30; i++) begin
            a_0 = W'($urandom); a_1 = W'($urandom); a_2 = W'($urandom); a_3 = W'($urandom);
            x_1 = W'($urandom); x_2 = W'($urandom); x_3 = W'($urandom);
            check_poly("poly_rand");
        end

        // Reset, then a long press.
        run(2);
        @(negedge clk);
        rst = 1'b0;
        btn = 1'b1;
        clear_stats();
        run(20);
        check_eq("press_pulses", 32'(pulses), 32'd1);
        check_eq("press_latency", 32'(first_pulse), 32'd6);

        // Release and wait for the low level to be accepted.
        btn = 1'b0;
        clear_stats();
        run(20);
        check_eq("release_pulses", 32'(pulses), 32'd0);

        // Short glitches are rejected.
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1; run(2);
            btn = 1'b0; run(2);
        end
        run(6);
        check_eq("glitch_pulses", 32'(pulses), 32'd0);

        // Press, release, press.
        clear_stats();
        btn = 1'b1; run(20);
        btn = 1'b0; run(20);
        check_eq("repress_mid", 32'(pulses), 32'd1);
        btn = 1'b1; run(20);
        check_eq("repress_total", 32'(pulses), 32'd2);

        // Short low bounce while held.
        clear_stats();
        btn = 1'b0; run(2);
        btn = 1'b1; run(12);
        check_eq("bounce_pulses", 32'(pulses), 32'd0);
        btn = 1'b0; run(20);

        // Reset in the middle of a press count.
        clear_stats();
        btn = 1'b1;
        run(4);
        rst = 1'b1;
        run(2);
        check_eq("midrst_none", 32'(pulses), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        run(15);
        check_eq("midrst_pulses", 32'(pulses), 32'd1);
        check_eq("midrst_latency", 32'(first_pulse), 32'd6);
        btn = 1'b0; run(20);

        // Random bouncy activity with occasional resets.
        clear_stats();
        for (int i = 0; i < 150; i++) begin
            btn = 1'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                run(1);
                @(negedge clk);
                rst = 1'b0;
            end
            run(int'($urandom_range(1, 8)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
